// File: rtl/winograd_pkg.sv
// winograd_pkg: shared sizing helper and accumulator state type for the winograd array and its post-processing stage
package winograd_pkg;
    typedef enum logic {IDLE, ACCUM} acc_state_t;
    function automatic int out_size(input int in0, input int in1, input int arr);
        int m;
        m = (in0 > in1 ? in0 : in1) + 1;
        return 2 * m + 2 * ($clog2(((m + 2) / 3) * arr / 2) - 1);
    endfunction
endpackage

// File: rtl/winograd_acc.sv
// winograd_acc: sums the array's redundant partials, accumulates a programmable tile count,
// removes the correction term once and posts one signed result per vector over valid/ready
module winograd_acc
    import winograd_pkg::*;
#(
    parameter int IN_SIZE_0  = 4,
    parameter int IN_SIZE_1  = 8,
    parameter int ARRAY_SIZE = 8,
    parameter int ACC_SIZE   = 32,
    parameter int CNT_W      = 8,
    localparam int OUT_SIZE  = out_size(IN_SIZE_0, IN_SIZE_1, ARRAY_SIZE)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [CNT_W-1:0]    len_i,
    input  logic [ACC_SIZE-1:0] corr_i,
    input  logic                in_valid_i,
    input  logic [OUT_SIZE-1:0] in_0_i,
    input  logic [OUT_SIZE-1:0] in_1_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [ACC_SIZE-1:0] out_data_o,
    output logic                busy_o,
    output logic                overrun_o
);
    acc_state_t          r_state;
    logic [ACC_SIZE-1:0] r_acc, r_out_data;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_out_valid, r_overrun;
    logic [ACC_SIZE-1:0] w_tile, w_neg_corr, w_post_data;
    logic                w_last, w_idle_start, w_idle_done, w_post;

    assign w_tile = {{(ACC_SIZE-OUT_SIZE){in_0_i[OUT_SIZE-1]}}, in_0_i}
                  + {{(ACC_SIZE-OUT_SIZE){in_1_i[OUT_SIZE-1]}}, in_1_i};
    assign w_neg_corr   = -corr_i;
    assign w_last       = r_state == ACCUM && in_valid_i && r_cnt == CNT_W'(1);
    assign w_idle_start = r_state == IDLE && start_i;
    // A vector that completes on its start cycle (len 0, or len 1 with its tile) never enters ACCUM
    assign w_idle_done  = w_idle_start && (len_i == '0 || (len_i == CNT_W'(1) && in_valid_i));
    assign w_post       = w_last || w_idle_done;
    assign w_post_data  = w_last ? r_acc + w_tile
                        : (len_i == '0 ? w_neg_corr : w_neg_corr + w_tile);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_idle_start && !w_idle_done) begin
                r_state <= ACCUM;
                r_acc   <= in_valid_i ? w_neg_corr + w_tile : w_neg_corr;
                r_cnt   <= len_i - CNT_W'(in_valid_i);
            end else if (w_last) begin
                r_state <= (start_i && len_i != '0) ? ACCUM : IDLE;
                r_acc   <= w_neg_corr;
                r_cnt   <= len_i;
            end else if (r_state == ACCUM && in_valid_i) begin
                r_acc <= r_acc + w_tile;
                r_cnt <= r_cnt - CNT_W'(1);
            end
            // A held, unaccepted result wins over a newly posted one
            if (w_post) begin
                if (r_out_valid && !out_ready_i) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_post_data;
                end
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign busy_o      = r_state == ACCUM;
    assign overrun_o   = r_overrun;
endmodule

// File: tb/tb_winograd_acc.sv
// tb_winograd_acc: directed literal checks plus randomized vectors against a per-cycle behavioural model
module tb_winograd_acc;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  len_i = '0;
    logic [31:0] corr_i = '0;
    logic        in_valid_i = 1'b0;
    logic [23:0] in_0_i = '0, in_1_i = '0;
    logic        out_valid_o, out_ready_i = 1'b0;
    logic [31:0] out_data_o;
    logic        busy_o, overrun_o;
    int          errors = 0, checks = 0;
    bit          chk_en = 1'b0;

    winograd_acc dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .corr_i(corr_i),
        .in_valid_i(in_valid_i), .in_0_i(in_0_i), .in_1_i(in_1_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o), .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model: vector bookkeeping with plain integers, then the result slot
    bit m_busy, m_hv, m_over;
    int m_rem, m_sum, m_hd;
    always @(posedge clk_i) begin
        bit post;
        int pd, tile;
        post = 0;
        pd = 0;
        tile = int'($signed(in_0_i)) + int'($signed(in_1_i));
        if (rst_i) begin
            m_busy = 0; m_hv = 0; m_over = 0; m_rem = 0; m_sum = 0; m_hd = 0;
        end else begin
            if (!m_busy) begin
                if (start_i) begin
                    m_sum = -int'(corr_i);
                    m_rem = int'(len_i);
                    if (m_rem > 0 && in_valid_i) begin
                        m_sum += tile;
                        m_rem--;
                    end
                    if (m_rem == 0) begin
                        post = 1;
                        pd = m_sum;
                    end
                    m_busy = m_rem > 0;
                end
            end else if (in_valid_i) begin
                m_sum += tile;
                m_rem--;
                if (m_rem == 0) begin
                    post = 1;
                    pd = m_sum;
                    m_busy = 0;
                    if (start_i && len_i != 0) begin
                        m_busy = 1;
                        m_sum = -int'(corr_i);
                        m_rem = int'(len_i);
                    end
                end
            end
            if (post) begin
                if (m_hv && !out_ready_i) m_over = 1;
                else begin
                    m_hv = 1;
                    m_hd = pd;
                end
            end else if (out_ready_i) m_hv = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) if (chk_en) begin
        chk("model_valid", 32'(out_valid_o), 32'(m_hv));
        chk("model_busy", 32'(busy_o), 32'(m_busy));
        chk("model_overrun", 32'(overrun_o), 32'(m_over));
        if (m_hv) chk("model_data", out_data_o, m_hd);
    end

    task automatic cyc(input logic st, input logic [7:0] ln, input logic [31:0] co,
                       input logic v, input logic [23:0] a, input logic [23:0] b, input logic rd);
        start_i = st; len_i = ln; corr_i = co; in_valid_i = v; in_0_i = a; in_1_i = b; out_ready_i = rd;
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        int rem, nl;
        bit b2b, tv;
        logic [31:0] rc;
        rst_i = 1;
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        chk_en = 1;
        rst_i = 0;
        chk("rst_valid", 32'(out_valid_o), 0);
        chk("rst_data", out_data_o, 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_overrun", 32'(overrun_o), 0);
        // Basic: -10 + 12 - 2 + 50
        cyc(1, 3, 10, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 5, 7, 0);
        cyc(0, 0, 0, 1, -24'sd3, 1, 0);
        chk("basic_not_yet", 32'(out_valid_o), 0);
        cyc(0, 0, 0, 1, 100, -24'sd50, 0);
        chk("basic_valid", 32'(out_valid_o), 1);
        chk("basic_data", out_data_o, 50);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
        chk("basic_hold", out_data_o, 50);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("basic_accepted", 32'(out_valid_o), 0);
        // Sign extension
        cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 24'h800000, 24'h800000, 1);
        chk("sext_data", out_data_o, 32'hFF000000);
        cyc(0, 0, 0, 0, 0, 0, 1);
        // Back-to-back
        cyc(1, 2, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1, 1, 1);
        cyc(1, 1, -32'sd4, 1, 2, 2, 1);
        chk("b2b_first", out_data_o, 6);
        chk("b2b_busy", 32'(busy_o), 1);
        cyc(0, 0, 0, 1, 3, 0, 1);
        chk("b2b_second_valid", 32'(out_valid_o), 1);
        chk("b2b_second", out_data_o, 7);
        cyc(0, 0, 0, 0, 0, 0, 1);
        // Overrun
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 4, 5, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 5, 6, 0);
        chk("ovr_flag", 32'(overrun_o), 1);
        chk("ovr_data", out_data_o, 9);
        cyc(0, 0, 0, 0, 0, 0, 1);
        // Reset mid-operation
        cyc(1, 4, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1, 1, 1);
        cyc(0, 0, 0, 1, 1, 1, 1);
        rst_i = 1;
        cyc(0, 0, 0, 0, 0, 0, 1);
        rst_i = 0;
        chk("midrst_valid", 32'(out_valid_o), 0);
        chk("midrst_busy", 32'(busy_o), 0);
        chk("midrst_overrun", 32'(overrun_o), 0);
        cyc(0, 0, 0, 1, 1, 1, 1);
        chk("midrst_ignored", 32'(out_valid_o), 0);
        cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 3, 4, 1);
        chk("midrst_after", out_data_o, 7);
        cyc(0, 0, 0, 0, 0, 0, 1);
        // Randomized vectors; ready toggles randomly so holds and overruns occur
        rem = 0;
        for (int v = 0; v < 100; v++) begin
            if (rem == 0) begin
                nl = $urandom_range(0, 5);
                rc = 32'($signed(16'($urandom)));
                tv = nl >= 2 && $urandom_range(0, 1) == 1;
                cyc(1, 8'(nl), rc, tv, 24'($urandom), 24'($urandom), 1'($urandom));
                rem = nl - int'(tv);
            end
            while (rem > 0) begin
                repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 0, 24'($urandom), 0, 1'($urandom));
                if (rem == 1) begin
                    b2b = v < 99 && $urandom_range(0, 2) == 0;
                    nl = $urandom_range(1, 5);
                    rc = 32'($signed(16'($urandom)));
                    cyc(b2b, 8'(nl), rc, 1, 24'($urandom), 24'($urandom), 1'($urandom));
                    rem = b2b ? nl : 0;
                    break;
                end
                cyc(1'($urandom_range(0, 3) == 0), 8'($urandom_range(1, 5)), $urandom, 1,
                    24'($urandom), 24'($urandom), 1'($urandom));
                rem--;
            end
        end
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 1);
        chk("drain_valid", 32'(out_valid_o), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
